// File: rtl/ibex_wb_xbar.sv
// ibex_wb_xbar
// Crossbar from NrHosts Ibex-protocol hosts to NrDevices Wishbone pipelined
// devices. Each device has its own small FSM with a round-robin arbiter and a
// watchdog. Each host may have at most one transaction in flight. Requests
// that match no device are answered locally with an error response.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   host_req_i/we/addr/be/wdata   Ibex request, one entry per host
//   host_gnt_o/rvalid/err/rdata   Ibex response, one entry per host
//   dev_cyc_o/stb/we/adr/dat/sel  Wishbone request, one entry per device
//   dev_stall_i/ack/err/dat       Wishbone response, one entry per device
//
// Device FSM
//   state  | meaning
//   IDLE   | no owner; arbitrate among eligible hosts decoding here
//   REQ    | cyc=stb=1, waiting for the device to accept (stall low)
//   WAIT   | cyc=1, stb=0, waiting for ack or err
module ibex_wb_xbar #(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned NrDevices     = 9,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter logic [NrDevices*AddressWidth-1:0] SlaveAddr = {
        32'h8000_7000, 32'h8000_6000, 32'h8000_5000, 32'h8000_4000,
        32'h8000_3000, 32'h8000_2000, 32'h8000_1000, 32'h8000_0000,
        32'h0010_0000},
    parameter logic [NrDevices*AddressWidth-1:0] SlaveMask = {
        {8{32'hFFFF_F000}}, 32'hFFF0_0000},
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    host_req_i    [NrHosts],
    input  logic                    host_we_i     [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic                    host_gnt_o    [NrHosts],
    output logic                    host_rvalid_o [NrHosts],
    output logic                    host_err_o    [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],

    output logic                    dev_cyc_o     [NrDevices],
    output logic                    dev_stb_o     [NrDevices],
    output logic                    dev_we_o      [NrDevices],
    output logic [AddressWidth-1:0] dev_adr_o     [NrDevices],
    output logic [DataWidth-1:0]    dev_dat_o     [NrDevices],
    output logic [DataWidth/8-1:0]  dev_sel_o     [NrDevices],
    input  logic                    dev_stall_i   [NrDevices],
    input  logic                    dev_ack_i     [NrDevices],
    input  logic                    dev_err_i     [NrDevices],
    input  logic [DataWidth-1:0]    dev_dat_i     [NrDevices]
);

    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned BeW      = DataWidth / 8;
    localparam bit          WdEn     = (TimeoutCycles != 0);
    localparam logic [31:0] WdLast   = 32'(TimeoutCycles) - 32'd1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e                  state_q [NrDevices];
    logic [HostIdxW-1:0]     rr_q    [NrDevices];
    logic [HostIdxW-1:0]     owner_q [NrDevices];
    logic [31:0]             wd_q    [NrDevices];
    logic [AddressWidth-1:0] adr_q   [NrDevices];
    logic [DataWidth-1:0]    dat_q   [NrDevices];
    logic [BeW-1:0]          sel_q   [NrDevices];
    logic                    we_q    [NrDevices];

    logic                    outst_q  [NrHosts];
    logic                    rvalid_q [NrHosts];
    logic                    err_q    [NrHosts];
    logic [DataWidth-1:0]    rdata_q  [NrHosts];

    logic                    host_hit [NrHosts];
    int unsigned             host_dev [NrHosts];
    logic                    eligible [NrHosts];
    logic                    unmapped [NrHosts];
    logic                    accept   [NrHosts];
    logic                    gnt      [NrHosts];
    logic                    rsp_vld  [NrHosts];
    logic                    rsp_err  [NrHosts];
    logic [DataWidth-1:0]    rsp_data [NrHosts];

    logic                    pick_vld    [NrDevices];
    logic [HostIdxW-1:0]     pick_idx    [NrDevices];
    logic [HostIdxW-1:0]     rr_next     [NrDevices];
    logic                    dev_resp    [NrDevices];
    logic                    dev_timeout [NrDevices];

    // Address decode; the first (lowest-index) matching device wins.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_hit[h] = 1'b0;
            host_dev[h] = 0;
            for (int unsigned i = 0; i < NrDevices; i++) begin
                if (!host_hit[h] &&
                    ((host_addr_i[h] & SlaveMask[i*AddressWidth +: AddressWidth]) ==
                     (SlaveAddr[i*AddressWidth +: AddressWidth] &
                      SlaveMask[i*AddressWidth +: AddressWidth]))) begin
                    host_hit[h] = 1'b1;
                    host_dev[h] = i;
                end
            end
            eligible[h] = host_req_i[h] && !outst_q[h];
            unmapped[h] = rst_ni && eligible[h] && !host_hit[h];
        end
    end

    // Round-robin pick per idle device, scanning from rr_q upwards.
    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            pick_vld[d] = 1'b0;
            pick_idx[d] = '0;
            for (int unsigned k = 0; k < NrHosts; k++) begin
                int unsigned c;
                c = 32'(rr_q[d]) + k;
                if (c >= NrHosts) begin
                    c = c - NrHosts;
                end
                if ((state_q[d] == StIdle) && !pick_vld[d] && eligible[c] &&
                    host_hit[c] && (host_dev[c] == d)) begin
                    pick_vld[d] = 1'b1;
                    pick_idx[d] = HostIdxW'(c);
                end
            end
            rr_next[d] = ((32'(pick_idx[d]) + 32'd1) >= NrHosts) ? '0 : pick_idx[d] + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            // Responses only count in WAIT; stray ack/err elsewhere is dropped.
            dev_resp[d]    = (state_q[d] == StWait) && (dev_ack_i[d] || dev_err_i[d]);
            dev_timeout[d] = WdEn && (state_q[d] != StIdle) && (wd_q[d] == WdLast);
        end
    end

    // Per-host grant and response collection. A host owns at most one
    // device (or the local error path) at a time, so the sources never collide.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            gnt[h]      = unmapped[h];
            accept[h]   = unmapped[h];
            rsp_vld[h]  = unmapped[h];
            rsp_err[h]  = unmapped[h];
            rsp_data[h] = '0;
            for (int unsigned d = 0; d < NrDevices; d++) begin
                if (32'(owner_q[d]) == h) begin
                    // A timeout in REQ still grants so the host sees gnt before rvalid.
                    if (rst_ni && (state_q[d] == StReq) && (!dev_stall_i[d] || dev_timeout[d])) begin
                        gnt[h] = 1'b1;
                    end
                    if (dev_resp[d]) begin
                        rsp_vld[h]  = 1'b1;
                        rsp_err[h]  = dev_err_i[d];
                        rsp_data[h] = dev_err_i[d] ? '0 : dev_dat_i[d];
                    end else if (dev_timeout[d]) begin
                        rsp_vld[h]  = 1'b1;
                        rsp_err[h]  = 1'b1;
                        rsp_data[h] = '0;
                    end
                end
                if (pick_vld[d] && (32'(pick_idx[d]) == h)) begin
                    accept[h] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned d = 0; d < NrDevices; d++) begin
                state_q[d] <= StIdle;
                rr_q[d]    <= '0;
                owner_q[d] <= '0;
                wd_q[d]    <= '0;
                adr_q[d]   <= '0;
                dat_q[d]   <= '0;
                sel_q[d]   <= '0;
                we_q[d]    <= 1'b0;
            end
            for (int unsigned h = 0; h < NrHosts; h++) begin
                outst_q[h]  <= 1'b0;
                rvalid_q[h] <= 1'b0;
                err_q[h]    <= 1'b0;
                rdata_q[h]  <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < NrDevices; d++) begin
                case (state_q[d])
                    StIdle: begin
                        wd_q[d] <= '0;
                        if (pick_vld[d]) begin
                            adr_q[d]   <= host_addr_i[pick_idx[d]];
                            dat_q[d]   <= host_wdata_i[pick_idx[d]];
                            sel_q[d]   <= host_be_i[pick_idx[d]];
                            we_q[d]    <= host_we_i[pick_idx[d]];
                            owner_q[d] <= pick_idx[d];
                            rr_q[d]    <= rr_next[d];
                            state_q[d] <= StReq;
                        end
                    end
                    StReq: begin
                        wd_q[d] <= wd_q[d] + 32'd1;
                        if (dev_timeout[d]) begin
                            state_q[d] <= StIdle;
                        end else if (!dev_stall_i[d]) begin
                            state_q[d] <= StWait;
                        end
                    end
                    StWait: begin
                        wd_q[d] <= wd_q[d] + 32'd1;
                        if (dev_resp[d] || dev_timeout[d]) begin
                            state_q[d] <= StIdle;
                        end
                    end
                    default: state_q[d] <= StIdle;
                endcase
            end
            for (int unsigned h = 0; h < NrHosts; h++) begin
                rvalid_q[h] <= rsp_vld[h];
                err_q[h]    <= rsp_err[h];
                if (rsp_vld[h]) begin
                    rdata_q[h] <= rsp_data[h];
                end
                // Host stays blocked through its rvalid cycle.
                if (accept[h]) begin
                    outst_q[h] <= 1'b1;
                end else if (rvalid_q[h]) begin
                    outst_q[h] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = gnt[h];
            host_rvalid_o[h] = rvalid_q[h];
            host_err_o[h]    = err_q[h];
            host_rdata_o[h]  = rdata_q[h];
        end
        for (int unsigned d = 0; d < NrDevices; d++) begin
            dev_cyc_o[d] = (state_q[d] != StIdle);
            dev_stb_o[d] = (state_q[d] == StReq);
            dev_we_o[d]  = we_q[d];
            dev_adr_o[d] = adr_q[d];
            dev_dat_o[d] = dat_q[d];
            dev_sel_o[d] = sel_q[d];
        end
    end

endmodule

// File: doc/ibex_wb_xbar.md
IBEX_WB_XBAR -- requirements
Module: ibex_wb_xbar

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of Ibex-protocol hosts.
REQ-002 SHALL have parameter NrDevices, default 9, number of Wishbone pipelined devices.
REQ-003 SHALL have parameters DataWidth = 32 and AddressWidth = 32, the data and address widths.
REQ-004 SHALL have parameters SlaveAddr and SlaveMask, default the codebase map, packed NrDevices*AddressWidth, device i at slice i.
REQ-005 SHALL have parameter TimeoutCycles, default 255, the per-transaction watchdog limit; 0 disables it.
REQ-006 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have ports host_req_i/host_we_i (in, 1), host_addr_i (in, AddressWidth), host_be_i (in, DataWidth/8) and host_wdata_i (in, DataWidth), each [NrHosts], the Ibex request.
REQ-009 SHALL have ports host_gnt_o/host_rvalid_o/host_err_o (out, 1) and host_rdata_o (out, DataWidth), each [NrHosts], the Ibex response.
REQ-010 SHALL have ports dev_cyc_o/dev_stb_o/dev_we_o (out, 1), dev_adr_o (out, AddressWidth), dev_dat_o (out, DataWidth) and dev_sel_o (out, DataWidth/8), each [NrDevices], the Wishbone request.
REQ-011 SHALL have ports dev_stall_i/dev_ack_i/dev_err_i (in, 1) and dev_dat_i (in, DataWidth), each [NrDevices], the Wishbone response.

Function
REQ-012 SHALL decode a host to device i when (host_addr_i & mask_i) == (addr_i & mask_i); on multiple matches the lowest index SHALL win.
REQ-013 SHALL allow at most one outstanding transaction per host, from acceptance until its host_rvalid_o cycle; a host with one outstanding SHALL NOT be arbitrated.
REQ-014 Each device SHALL run FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-015 IDLE: among eligible requesting hosts that decode to the device, a round-robin winner SHALL be picked, starting from pointer rr_i.
REQ-016 On that pick, the winner's addr/we/be/wdata SHALL be registered, the owner recorded, rr_i set to winner+1 mod NrHosts, and the FSM SHALL go to REQ.
REQ-017 REQ: cyc=1, stb=1 and the registered fields SHALL be driven; when dev_stall_i=0, host_gnt_o[owner] SHALL be 1 that cycle and the FSM SHALL go to WAIT.
REQ-018 WAIT: cyc=1 and stb=0; on dev_ack_i or dev_err_i the FSM SHALL go to IDLE, capture dev_dat_i, and drive host_rvalid_o=1 for exactly one cycle on the next cycle.
REQ-019 In that rvalid cycle, host_err_o SHALL equal dev_err_i, and host_rdata_o SHALL be the captured data (0 when err).
REQ-020 If ack and err are both set, err SHALL take priority; ack/err seen in IDLE or REQ SHALL be ignored.
REQ-021 Minimum latency SHALL be: req at cycle 0, gnt at 1, ack at 2, rvalid at 3.
REQ-022 The watchdog SHALL count cycles in REQ+WAIT and clear in IDLE; when it reaches TimeoutCycles, the FSM SHALL go to IDLE with cyc dropped.
REQ-023 On a timeout in REQ, host_gnt_o SHALL also pulse that cycle; on any timeout, host_rvalid_o=1, host_err_o=1 and rdata=0 SHALL follow one cycle later.
REQ-024 A request that decodes to no device SHALL get host_gnt_o=1 in the same cycle, then host_rvalid_o=1, host_err_o=1 and rdata=0 the next cycle, with no device activity.
REQ-025 host_gnt_o SHALL never pulse without a matching later rvalid; each host SHALL receive responses in request order.
REQ-026 Device FSMs SHALL be independent; different hosts to different devices SHALL proceed concurrently.
REQ-027 When idle, dev_adr_o, dev_dat_o, dev_sel_o and dev_we_o SHALL hold their last value, and dev_cyc_o and dev_stb_o SHALL be 0.

Reset
REQ-028 While rst_ni=0 at a clock edge: all FSMs IDLE, rr_i=0, watchdogs 0, owners cleared, outstanding flags cleared.
REQ-029 While rst_ni=0 at a clock edge: every output 0 from the next cycle.
REQ-030 A reset mid-transaction SHALL drop cyc/stb on the following edge and SHALL NOT produce a host_rvalid_o for the aborted transaction.

Verification
REQ-031 Host0 reads 0x80001004 (UART), no stall, ack at cycle 2 with dat 0xDEADBEEF -> gnt cycle 1, rvalid cycle 3, rdata 0xDEADBEEF, err 0.
REQ-032 Hosts 0 and 1 both request RAM 0x00100000 at cycle 0 with rr=0 -> host0 is served first, host1 is granted after host0's ack, then rr=0 again.
REQ-033 Host0 requests 0x40000000 (unmapped) -> gnt in the same cycle, next cycle rvalid=1, err=1, rdata=0; all dev_cyc_o stay 0.
REQ-034 TimeoutCycles=4, device never acks -> cyc drops after 4 cycles in REQ+WAIT, then one rvalid with err=1; stall held -> gnt pulses at timeout.
REQ-035 Ack and err in the same WAIT cycle -> err=1; rst_ni=0 during WAIT -> cyc=0 next cycle and no rvalid is ever produced.
